// File: rtl/fccc_pkg.sv
// Shared definitions for the CCC clock-enable sequencer: lock FSM states,
// legal parameter ranges and a select-width helper.
package fccc_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_FILTER   = 2'd1,
        ST_RELEASE  = 2'd2,
        ST_RUN      = 2'd3
    } fccc_state_e;

    localparam int NUM_CH_MIN      = 1;
    localparam int NUM_CH_MAX      = 8;
    localparam int LOCK_FILTER_MIN = 1;
    localparam int RST_STAGGER_MIN = 1;

    // Width of an index selecting one of v items, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return ($clog2(v) < 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/fccc_clken_div.sv
// One output channel: free-running divider counter with a pending/active
// divider pair so reprogramming only takes effect on a period boundary.
module fccc_clken_div #(
    parameter int DIV_W    = 8,
    parameter int DIV_INIT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ch_rst,
    input  logic             ch_rst_nxt,
    input  logic             cfg_we,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             clken
);

    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] pend_r;
    logic             pend_vld_r;
    logic             term_s;
    logic             apply_s;
    logic [DIV_W-1:0] new_div_s;

    // Terminal decode and divider-update selection; a same-cycle write wins over the pending copy.
    always_comb begin
        term_s    = !ch_rst && (cnt_r == div_r);
        apply_s   = (term_s || ch_rst) && (cfg_we || pend_vld_r);
        new_div_s = cfg_we ? cfg_div : pend_r;
    end

    assign clken = term_s;

    // Period counter; also cleared on the edge that enters channel reset so it reads 0 throughout reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {DIV_W{1'b0}};
        end else if (ch_rst_nxt || ch_rst || term_s) begin
            cnt_r <= {DIV_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    // Active and pending divider values.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r      <= DIV_W'(DIV_INIT);
            pend_r     <= {DIV_W{1'b0}};
            pend_vld_r <= 1'b0;
        end else if (apply_s) begin
            div_r      <= new_div_s;
            pend_vld_r <= 1'b0;
        end else if (cfg_we) begin
            pend_r     <= cfg_div;
            pend_vld_r <= 1'b1;
        end else begin
            pend_vld_r <= pend_vld_r;
        end
    end

endmodule

// File: rtl/fccc_clken_seq.sv
// CCC lock qualifier and staggered per-channel reset release, driving a
// bank of programmable clock-enable dividers.
module fccc_clken_seq
    import fccc_pkg::*;
#(
    parameter  int NUM_CH      = 3,
    parameter  int DIV_W       = 8,
    parameter  int DIV_INIT    = 0,
    parameter  int LOCK_FILTER = 16,
    parameter  int RST_STAGGER = 4,
    localparam int SEL_W       = clog2_min1(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              LOCK_IN,
    input  logic              CFG_WE,
    input  logic [SEL_W-1:0]  CFG_SEL,
    input  logic [DIV_W-1:0]  CFG_DIV,
    input  logic              LOCK_LOST_CLR,
    output logic [NUM_CH-1:0] CLKEN,
    output logic [NUM_CH-1:0] CH_RESET,
    output logic              LOCKED,
    output logic              LOCK_LOST
);

    localparam int FW = $clog2(LOCK_FILTER + 1);
    localparam int SW = clog2_min1(RST_STAGGER);
    localparam int IW = $clog2(NUM_CH + 1);
    localparam logic [FW-1:0] LF_C      = FW'(LOCK_FILTER);
    localparam logic [SW-1:0] ST_LAST_C = SW'(RST_STAGGER - 1);
    localparam logic [IW-1:0] NCH_C     = IW'(NUM_CH);

    fccc_state_e       state_r, state_nxt_s;
    logic [FW-1:0]     filt_r, filt_nxt_s;
    logic [SW-1:0]     stag_r, stag_nxt_s;
    logic [IW-1:0]     idx_r, idx_nxt_s;
    logic [NUM_CH-1:0] ch_reset_r, ch_reset_nxt_s;
    logic              locked_r, locked_nxt_s;
    logic              lost_r, lost_nxt_s;
    logic              lock_loss_s;
    logic [NUM_CH-1:0] ch_we_s;

    assign lock_loss_s = ((state_r == ST_RELEASE) || (state_r == ST_RUN)) && !LOCK_IN;

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_UNLOCKED;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_UNLOCKED: state_nxt_s = LOCK_IN ? ST_FILTER : ST_UNLOCKED;
            ST_FILTER: begin
                if (!LOCK_IN) begin
                    state_nxt_s = ST_UNLOCKED;
                end else if (filt_r >= LF_C) begin
                    state_nxt_s = ST_RELEASE;
                end else begin
                    state_nxt_s = ST_FILTER;
                end
            end
            ST_RELEASE: begin
                if (!LOCK_IN) begin
                    state_nxt_s = ST_UNLOCKED;
                end else if (idx_r == NCH_C) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_RELEASE;
                end
            end
            ST_RUN:  state_nxt_s = LOCK_IN ? ST_RUN : ST_UNLOCKED;
            default: state_nxt_s = ST_UNLOCKED;
        endcase
    end

    // Next values of the filter/stagger counters and registered outputs.
    always_comb begin
        filt_nxt_s     = filt_r;
        stag_nxt_s     = stag_r;
        idx_nxt_s      = idx_r;
        ch_reset_nxt_s = ch_reset_r;
        case (state_r)
            ST_UNLOCKED: begin
                filt_nxt_s     = LOCK_IN ? FW'(1) : FW'(0);
                stag_nxt_s     = SW'(0);
                idx_nxt_s      = IW'(0);
                ch_reset_nxt_s = {NUM_CH{1'b1}};
            end
            ST_FILTER: begin
                if (!LOCK_IN) begin
                    filt_nxt_s = FW'(0);
                end else if (filt_r >= LF_C) begin
                    ch_reset_nxt_s[0] = 1'b0;
                    stag_nxt_s        = SW'(0);
                    idx_nxt_s         = IW'(1);
                end else begin
                    filt_nxt_s = filt_r + FW'(1);
                end
            end
            ST_RELEASE: begin
                if (!LOCK_IN) begin
                    filt_nxt_s     = FW'(0);
                    stag_nxt_s     = SW'(0);
                    idx_nxt_s      = IW'(0);
                    ch_reset_nxt_s = {NUM_CH{1'b1}};
                end else if (idx_r == NCH_C) begin
                    stag_nxt_s = SW'(0);
                end else if (stag_r == ST_LAST_C) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        ch_reset_nxt_s[i] = (idx_r == IW'(i)) ? 1'b0 : ch_reset_r[i];
                    end
                    idx_nxt_s  = idx_r + IW'(1);
                    stag_nxt_s = SW'(0);
                end else begin
                    stag_nxt_s = stag_r + SW'(1);
                end
            end
            ST_RUN: begin
                if (!LOCK_IN) begin
                    filt_nxt_s     = FW'(0);
                    stag_nxt_s     = SW'(0);
                    idx_nxt_s      = IW'(0);
                    ch_reset_nxt_s = {NUM_CH{1'b1}};
                end else begin
                    ch_reset_nxt_s = ch_reset_r;
                end
            end
            default: begin
                filt_nxt_s     = FW'(0);
                stag_nxt_s     = SW'(0);
                idx_nxt_s      = IW'(0);
                ch_reset_nxt_s = {NUM_CH{1'b1}};
            end
        endcase
        locked_nxt_s = (state_nxt_s == ST_RELEASE) || (state_nxt_s == ST_RUN);
        // A fresh loss beats a simultaneous clear.
        lost_nxt_s   = lock_loss_s ? 1'b1 : (LOCK_LOST_CLR ? 1'b0 : lost_r);
    end

    // Sequencer registers and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            filt_r     <= FW'(0);
            stag_r     <= SW'(0);
            idx_r      <= IW'(0);
            ch_reset_r <= {NUM_CH{1'b1}};
            locked_r   <= 1'b0;
            lost_r     <= 1'b0;
        end else begin
            filt_r     <= filt_nxt_s;
            stag_r     <= stag_nxt_s;
            idx_r      <= idx_nxt_s;
            ch_reset_r <= ch_reset_nxt_s;
            locked_r   <= locked_nxt_s;
            lost_r     <= lost_nxt_s;
        end
    end

    // Per-channel write strobes; out-of-range selects match no channel.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_we_s[i] = CFG_WE && (CFG_SEL == SEL_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        fccc_clken_div #(
            .DIV_W    (DIV_W),
            .DIV_INIT (DIV_INIT)
        ) u_div (
            .clk        (CLK),
            .reset      (RESET),
            .ch_rst     (ch_reset_r[g]),
            .ch_rst_nxt (ch_reset_nxt_s[g]),
            .cfg_we     (ch_we_s[g]),
            .cfg_div    (CFG_DIV),
            .clken      (CLKEN[g])
        );
    end

    assign CH_RESET  = ch_reset_r;
    assign LOCKED    = locked_r;
    assign LOCK_LOST = lost_r;

endmodule
